// File: rtl/pn_bert_checker_pkg.sv
// Purpose: shared state encodings and default thresholds for the PN BER checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pn_bert_checker_pkg;

  typedef enum logic [1:0] {
    PNCHK_SEARCH = 2'd0,
    PNCHK_VERIFY = 2'd1,
    PNCHK_LOCKED = 2'd2
  } pnChkState_t;

  // Reset-time defaults a register block can load into verifyThresh/lossThresh.
  localparam logic [7:0]  PNCHK_DEF_VERIFY_THRESH = 8'd4;
  localparam logic [15:0] PNCHK_DEF_LOSS_THRESH   = 16'd16;

endpackage

// File: rtl/pn_bert_checker_if.sv
// Purpose: bit stream, configuration and BER result bundle for the PN checker.
// Latency: n/a (wiring only).
// Backpressure: none; bitEn qualifies each bit and the checker always accepts it.
interface pn_bert_checker_if #(
  parameter int MAX_LEN = 24,
  parameter int CNT_W   = 32
);
  logic               bitEn;
  logic               dataBit;
  logic [MAX_LEN-1:0] poly;
  logic [4:0]         polyLength;
  logic [7:0]         verifyThresh;
  logic [15:0]        lossThresh;
  logic               restart;
  logic               locked;
  logic [CNT_W-1:0]   bitCount;
  logic [CNT_W-1:0]   errCount;
  logic               errPulse;
  logic               lockLost;

  modport master (
    output bitEn, dataBit, poly, polyLength, verifyThresh, lossThresh, restart,
    input  locked, bitCount, errCount, errPulse, lockLost
  );

  modport slave (
    input  bitEn, dataBit, poly, polyLength, verifyThresh, lossThresh, restart,
    output locked, bitCount, errCount, errPulse, lockLost
  );
endinterface

// File: rtl/pn_chk_lfsr.sv
// Purpose: local PN LFSR; predicts the next bit and shifts in either received data or its own prediction.
// Latency: predicted is combinational from the register; shift takes effect on the qualifying edge.
// Backpressure: none; shifts on every shiftEn cycle.
module pn_chk_lfsr #(
  parameter int MAX_LEN = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shiftEn,
  input  logic               loadData,
  input  logic               dataBit,
  input  logic [MAX_LEN-1:0] poly,
  input  logic [4:0]         polyLength,
  output logic               predicted
);

  logic [MAX_LEN-1:0] sr;
  logic [MAX_LEN-1:0] lenMask;

  // Same taps-parity rule as the transmit LFSR: sr[0] is the newest bit, only stages below polyLength count.
  always_comb begin
    lenMask = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      lenMask[k] = (5'(k) < polyLength);
    end
    predicted = ^(sr & poly & lenMask);
  end

  // Shift register: SEARCH loads received bits, VERIFY/LOCKED flywheel on the prediction.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr <= '0;
    end else if (shiftEn) begin
      sr <= {sr[MAX_LEN-2:0], (loadData ? dataBit : predicted)};
    end
  end

endmodule

// File: rtl/pn_bert_checker.sv
// Purpose: self-synchronising PN checker; acquires lock, then counts checked bits and bit errors.
// Latency: all outputs registered, one cycle after the qualifying bitEn edge.
// Backpressure: none; every bitEn cycle is consumed, other cycles hold state with pulses low.
module pn_bert_checker
  import pn_bert_checker_pkg::*;
#(
  parameter int MAX_LEN     = 24,
  parameter int VERIFY_BITS = 64,
  parameter int WINDOW_BITS = 256,
  parameter int CNT_W       = 32
) (
  input logic              clk,
  input logic              reset,
  pn_bert_checker_if.slave bus
);

  localparam int VCNT_W = $clog2(VERIFY_BITS);
  localparam int WCNT_W = $clog2(WINDOW_BITS);

  pnChkState_t       state;
  logic [4:0]        fillCnt;
  logic [VCNT_W-1:0] vCnt;
  logic [7:0]        vErr;
  logic [WCNT_W-1:0] wCnt;
  logic [15:0]       wErr;
  logic [CNT_W-1:0]  bitCountR;
  logic [CNT_W-1:0]  errCountR;
  logic              lockedR;
  logic              errPulseR;
  logic              lockLostR;

  logic              predicted;
  logic              mismatch;
  logic [7:0]        vErrNext;
  logic [15:0]       wErrNext;
  logic [CNT_W-1:0]  bitCountNext;
  logic [CNT_W-1:0]  errCountNext;

  pn_chk_lfsr #(.MAX_LEN(MAX_LEN)) uLfsr (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.restart),
    .shiftEn    (bus.bitEn),
    .loadData   (state == PNCHK_SEARCH),
    .dataBit    (bus.dataBit),
    .poly       (bus.poly),
    .polyLength (bus.polyLength),
    .predicted  (predicted)
  );

  // Error detection and saturating next values for all counters.
  always_comb begin
    mismatch     = bus.dataBit ^ predicted;
    vErrNext     = (mismatch && (vErr != 8'hFF)) ? vErr + 8'd1 : vErr;
    wErrNext     = (mismatch && (wErr != 16'hFFFF)) ? wErr + 16'd1 : wErr;
    bitCountNext = (&bitCountR) ? bitCountR : bitCountR + CNT_W'(1);
    errCountNext = (mismatch && !(&errCountR)) ? errCountR + CNT_W'(1) : errCountR;
  end

  // Acquisition / lock state machine with registered status and counters; restart outranks bitEn.
  always_ff @(posedge clk) begin
    if (reset || bus.restart) begin
      state     <= PNCHK_SEARCH;
      fillCnt   <= '0;
      vCnt      <= '0;
      vErr      <= '0;
      wCnt      <= '0;
      wErr      <= '0;
      bitCountR <= '0;
      errCountR <= '0;
      lockedR   <= 1'b0;
      errPulseR <= 1'b0;
      lockLostR <= 1'b0;
    end else begin
      errPulseR <= 1'b0;
      lockLostR <= 1'b0;
      if (bus.bitEn) begin
        case (state)
          PNCHK_SEARCH: begin
            if (fillCnt + 5'd1 == bus.polyLength) begin
              state   <= PNCHK_VERIFY;
              fillCnt <= '0;
              vCnt    <= '0;
              vErr    <= '0;
            end else begin
              fillCnt <= fillCnt + 5'd1;
            end
          end
          PNCHK_VERIFY: begin
            if (vCnt == VCNT_W'(VERIFY_BITS - 1)) begin
              if (vErrNext <= bus.verifyThresh) begin
                state   <= PNCHK_LOCKED;
                lockedR <= 1'b1;
                wCnt    <= '0;
                wErr    <= '0;
              end else begin
                state   <= PNCHK_SEARCH;
                fillCnt <= '0;
              end
            end else begin
              vCnt <= vCnt + VCNT_W'(1);
              vErr <= vErrNext;
            end
          end
          PNCHK_LOCKED: begin
            bitCountR <= bitCountNext;
            errCountR <= errCountNext;
            errPulseR <= mismatch;
            if (wCnt == WCNT_W'(WINDOW_BITS - 1)) begin
              // Window closes on this bit; a zero threshold disables loss detection.
              wCnt <= '0;
              wErr <= '0;
              if ((bus.lossThresh != 16'd0) && (wErrNext >= bus.lossThresh)) begin
                state     <= PNCHK_SEARCH;
                fillCnt   <= '0;
                lockedR   <= 1'b0;
                lockLostR <= 1'b1;
              end
            end else begin
              wCnt <= wCnt + WCNT_W'(1);
              wErr <= wErrNext;
            end
          end
          default: begin
            state   <= PNCHK_SEARCH;
            fillCnt <= '0;
            lockedR <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked   = lockedR;
  assign bus.bitCount = bitCountR;
  assign bus.errCount = errCountR;
  assign bus.errPulse = errPulseR;
  assign bus.lockLost = lockLostR;

endmodule

// File: tb/tb_pn_bert_checker.sv
// Purpose: directed bench for the PN checker on a PN7 stream (x^7 + x^6 + 1).
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; stimulus drives bitEn directly.
module tb_pn_bert_checker;
  import pn_bert_checker_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pn_bert_checker_if #(.MAX_LEN(24), .CNT_W(32)) bus ();

  pn_bert_checker #(
    .MAX_LEN(24), .VERIFY_BITS(64), .WINDOW_BITS(256), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   compared   = 0;
  int   mismatched = 0;
  int   pnIdx      = 0;
  int   pulses     = 0;
  int   losses     = 0;
  logic pnBits [0:8191];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, sample 1 ns later.
  task automatic step(input logic en, input logic b, input logic rs);
    bus.bitEn   = en;
    bus.dataBit = b;
    bus.restart = rs;
    @(posedge clk);
    #1;
    bus.bitEn   = 1'b0;
    bus.restart = 1'b0;
    if (bus.errPulse === 1'b1) pulses++;
    if (bus.lockLost === 1'b1) losses++;
  endtask

  task automatic sendPn(input logic inv);
    step(1'b1, pnBits[pnIdx] ^ inv, 1'b0);
    pnIdx++;
  endtask

  task automatic sendPn3(input logic inv);
    sendPn(inv);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // PN7 reference stream: b[n] = b[n-6] ^ b[n-7], seeded 1,0,0,0,0,0,0.
    for (int n = 0; n < 8192; n++) begin
      if (n < 7) pnBits[n] = (n == 0);
      else       pnBits[n] = pnBits[n-6] ^ pnBits[n-7];
    end

    reset            = 1'b1;
    bus.bitEn        = 1'b0;
    bus.dataBit      = 1'b0;
    bus.restart      = 1'b0;
    bus.poly         = 24'h000060;
    bus.polyLength   = 5'd7;
    bus.verifyThresh = 8'd2;
    bus.lossThresh   = 16'd16;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_locked",   32'(bus.locked),   32'd0);
    check("rst_bitCount", bus.bitCount,      32'd0);
    check("rst_errCount", bus.errCount,      32'd0);
    check("rst_errPulse", 32'(bus.errPulse), 32'd0);
    check("rst_lockLost", 32'(bus.lockLost), 32'd0);

    // Clean PN7: 7 fill + 64 verify bits, lock visible after the 71st bit.
    for (int i = 0; i < 70; i++) sendPn(1'b0);
    check("acq_not_yet", 32'(bus.locked), 32'd0);
    sendPn(1'b0);
    check("acq_locked",   32'(bus.locked), 32'd1);
    check("acq_bitCount", bus.bitCount,    32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("idle_hold_locked", 32'(bus.locked), 32'd1);
    check("idle_hold_count",  bus.bitCount,    32'd0);

    pulses = 0;
    for (int i = 0; i < 1000; i++) sendPn(1'b0);
    check("clean_bitCount", bus.bitCount, 32'd1000);
    check("clean_errCount", bus.errCount, 32'd0);
    check("clean_pulses",   32'(pulses),  32'd0);

    // One inverted bit per 100: locked indices 1050, 1150, ... 1950.
    pulses = 0;
    losses = 0;
    for (int i = 0; i < 1000; i++) begin
      sendPn((i % 100) == 50);
      if (i == 50) check("err_pulse_cycle", 32'(bus.errPulse), 32'd1);
    end
    check("err_errCount", bus.errCount,    32'd10);
    check("err_pulses",   32'(pulses),     32'd10);
    check("err_bitCount", bus.bitCount,    32'd2000);
    check("err_locked",   32'(bus.locked), 32'd1);
    check("err_no_loss",  32'(losses),     32'd0);

    // lossThresh=0: window [1792,2047] ends with 2+48 errors yet lock holds.
    bus.lossThresh = 16'd0;
    for (int i = 0; i < 48; i++) sendPn(1'b1);
    check("thr0_locked",   32'(bus.locked), 32'd1);
    check("thr0_losses",   32'(losses),     32'd0);
    check("thr0_errCount", bus.errCount,    32'd58);
    check("thr0_bitCount", bus.bitCount,    32'd2048);

    // lossThresh=16: exactly 16 errors in window [2048,2303] drops lock at its last bit.
    bus.lossThresh = 16'd16;
    for (int i = 0; i < 16; i++) sendPn(1'b1);
    for (int i = 0; i < 239; i++) sendPn(1'b0);
    check("win_pre_locked", 32'(bus.locked),   32'd1);
    check("win_pre_lost",   32'(bus.lockLost), 32'd0);
    sendPn(1'b0);
    check("win_lockLost",  32'(bus.lockLost), 32'd1);
    check("win_unlocked",  32'(bus.locked),   32'd0);
    check("win_state",     32'(dut.state),    32'(PNCHK_SEARCH));
    check("win_bitCount",  bus.bitCount,      32'd2304);
    check("win_errCount",  bus.errCount,      32'd74);
    step(1'b0, 1'b0, 1'b0);
    check("win_lost_1cyc", 32'(bus.lockLost), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("hold_bitCount", bus.bitCount,    32'd2304);
    check("hold_errCount", bus.errCount,    32'd74);
    check("hold_unlocked", 32'(bus.locked), 32'd0);

    // Restart, then one corrupted fill bit with verifyThresh=0 -> verify fails, retry locks.
    step(1'b0, 1'b0, 1'b1);
    check("rs_bitCount", bus.bitCount, 32'd0);
    check("rs_errCount", bus.errCount, 32'd0);
    bus.verifyThresh = 8'd0;
    for (int i = 0; i < 71; i++) sendPn(i == 2);
    check("vfail_unlocked", 32'(bus.locked),   32'd0);
    check("vfail_no_lost",  32'(bus.lockLost), 32'd0);
    for (int i = 0; i < 70; i++) sendPn(1'b0);
    check("retry_not_yet", 32'(bus.locked), 32'd0);
    sendPn(1'b0);
    check("retry_locked", 32'(bus.locked), 32'd1);

    // Restart coinciding with a (corrupted) locked bit: that bit is not counted.
    for (int i = 0; i < 5; i++) sendPn(1'b0);
    check("pre_rs_bitCount", bus.bitCount, 32'd5);
    step(1'b1, pnBits[pnIdx] ^ 1'b1, 1'b1);
    pnIdx++;
    check("rsb_locked",   32'(bus.locked),   32'd0);
    check("rsb_bitCount", bus.bitCount,      32'd0);
    check("rsb_errCount", bus.errCount,      32'd0);
    check("rsb_errPulse", 32'(bus.errPulse), 32'd0);
    check("rsb_state",    32'(dut.state),    32'(PNCHK_SEARCH));

    // bitEn on every third cycle: same bit counts, three times the cycles.
    for (int i = 0; i < 70; i++) sendPn3(1'b0);
    check("slow_not_yet", 32'(bus.locked), 32'd0);
    sendPn3(1'b0);
    check("slow_locked", 32'(bus.locked), 32'd1);
    pulses = 0;
    for (int i = 0; i < 1000; i++) sendPn3(1'b0);
    check("slow_bitCount", bus.bitCount, 32'd1000);
    check("slow_errCount", bus.errCount, 32'd0);
    check("slow_pulses",   32'(pulses),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pn_bert_checker.md
Name: pn_bert_checker

Overview:
- Receive-side PN checker for the PN generator output (nrzBit/pnClkEn path), or for recovered demod data in loopback.
- Self-synchronises a local LFSR to the incoming PN stream, declares lock, then counts bits and bit errors for BER measurement.
- Sits directly downstream of the PN generator / bit-sync output; results go to a register block.

Parameters:
- MAX_LEN, 24, width of LFSR and poly tap mask
- VERIFY_BITS, 64, post-load bits that must be checked before lock is declared
- WINDOW_BITS, 256, bits per loss-of-lock evaluation window while locked
- CNT_W, 32, width of bit and error counters

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- bitEn  in  1  qualifies dataBit; one bit per asserted cycle
- dataBit  in  1  received serial PN bit
- poly  in  MAX_LEN  feedback tap mask; bit k = tap on stage k+1
- polyLength  in  5  active LFSR length, 2..MAX_LEN
- verifyThresh  in  8  max errors allowed during VERIFY to declare lock
- lossThresh  in  16  errors in one window that force loss of lock
- restart  in  1  one-cycle pulse: clears counters and returns to SEARCH
- locked  out  1  high in LOCKED state
- bitCount  out  CNT_W  bits checked while locked, saturating
- errCount  out  CNT_W  errors while locked, saturating
- errPulse  out  1  one-cycle flag: current locked bit mismatched
- lockLost  out  1  one-cycle flag on LOCKED->SEARCH

Behaviour:
- Reset or restart: state=SEARCH, LFSR=0, all counters 0, locked/errPulse/lockLost=0. restart dominates bitEn in the same cycle.
- LFSR convention: sr[0] = newest bit. predicted = XOR of (sr & poly) over bits [polyLength-1:0]. Shift: sr <= {sr[MAX_LEN-2:0], newBit}.
- All state changes only on cycles with bitEn=1; otherwise everything holds and pulses are 0.
- SEARCH:
  - newBit = dataBit; fillCnt++.
  - When fillCnt reaches polyLength: go to VERIFY and clear vCnt/vErr.
- VERIFY:
  - newBit = predicted; on dataBit != predicted, vErr++ (saturate at 255).
  - After VERIFY_BITS bits: vErr <= verifyThresh -> LOCKED, clear window counters, locked=1 on the next cycle. Otherwise -> SEARCH with fillCnt=0.
- LOCKED:
  - newBit = predicted (flywheel; received errors never enter the LFSR).
  - Each bit: bitCount++ and wCnt++. On mismatch: errCount++, wErr++, errPulse=1 the next cycle.
  - At wCnt=WINDOW_BITS, evaluated including the current bit: wErr >= lossThresh -> SEARCH, lockLost=1, locked=0 on the next cycle. Either way, clear wCnt/wErr.
  - lossThresh=0 never forces loss.
- Counters saturate at all-ones. bitCount and errCount hold their values across loss of lock; only reset or restart clears them.
- Registered outputs: 1-cycle latency from the qualifying bitEn edge.
- poly or polyLength changes take effect only after a restart. Behaviour with polyLength<2 is undefined; the bench must not drive it.
- LFSR all-zero with no taps hit: predicted=0. No lock-up protection is needed because SEARCH reloads from data.

Decomposition:
- Shared package/include holds the state encodings PNCHK_SEARCH=2'd0, PNCHK_VERIFY=2'd1, PNCHK_LOCKED=2'd2 and the default thresholds.
- One sub-module: pn_chk_lfsr, which computes the predicted bit and performs the shift with a select between loading dataBit and loading the predicted bit.
- Reuse the taps-parity convention already used by the transmit LFSR so that identical poly/length values produce matching sequences.

Test Plan:
- PN7: poly=24'h000060, polyLength=7, bitEn every cycle, clean stream -> locked rises 7+64+1 cycles after first bit. After a further 1000 bits: bitCount=1000, errCount=0.
- While locked, invert one bit every 100 bits over 1000 bits -> errCount=10, exactly 10 errPulse cycles, locked stays 1.
- lossThresh=16, WINDOW_BITS=256, then drive random data -> lockLost pulses at the first window end and the block re-enters SEARCH. Counters hold their prior values.
- Single error inside the SEARCH fill with verifyThresh=0 -> VERIFY fails and the block returns to SEARCH. Clean data then achieves lock on the next attempt.
- bitEn=1 on every 3rd cycle only -> lock latency scales ×3 and counts are identical to the continuous case.
- restart asserted in the same cycle as bitEn while locked -> next cycle locked=0, bitCount=0, errCount=0, state=SEARCH, and that bit is not counted.
